comparator_arbiter: RTL

- Shares one `comparatortree` instance (the existing combinational EQ/LT/LTu compare datapath) among NREQ requesters.
- Round-robin arbitration and operand capture, sequenced by a small FSM.
- Results are returned on a valid/ready response channel tagged with the requester ID.
- Sits between the execution clients and the single wide comparator, so the compare tree is not replicated per client.

---
 rtl/comparator_pkg.sv | 13 +
 rtl/comparatortree.sv | 16 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/comparator_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and defaults for the comparator arbiter slice.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    CMP2 = 2'd2,
    RSP  = 2'd3
  } cmp_arb_state_t;

  localparam int CMP_ARB_NREQ_DEFAULT = 4;

endpackage

// File: rtl/comparatortree.sv
// Combinational equality / signed / unsigned less-than compare datapath.
module comparatortree #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_grant
);

  int             sum;
  logic [IDW-1:0] idx;

  // Scan from the farthest candidate back to ptr so the closest one overwrites.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/comparator_arbiter.sv
// Shares one comparatortree among NREQ requesters with round-robin grant and a
// valid/ready response. COMPARATOR_ARBITER_PIPE_EN adds a CMP2 register stage.
module comparator_arbiter
  import comparator_pkg::*;
#(
  parameter  int WIDTH = 128,
  parameter  int NREQ  = CMP_ARB_NREQ_DEFAULT,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_eq,
  output logic                  rsp_lt,
  output logic                  rsp_ltu,
  output logic                  busy
);

  cmp_arb_state_t   state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             any_grant;
  logic             tree_eq;
  logic             tree_lt;
  logic             tree_ltu;

`ifdef COMPARATOR_ARBITER_PIPE_EN
  logic             pipe_eq;
  logic             pipe_lt;
  logic             pipe_ltu;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // The grant is only offered while idle, so a handshake can only happen there.
  assign req_ready = (state == IDLE) ? grant : '0;

  comparatortree #(.WIDTH(WIDTH)) u_comparatortree (
    .a   (op1_q),
    .b   (op2_q),
    .eq  (tree_eq),
    .lt  (tree_lt),
    .ltu (tree_ltu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the captured operands are reset too, so the tree never sees stale data after reset.
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_eq    <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_ltu   <= 1'b0;
      busy      <= 1'b0;
`ifdef COMPARATOR_ARBITER_PIPE_EN
      pipe_eq   <= 1'b0;
      pipe_lt   <= 1'b0;
      pipe_ltu  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block order-independent.
      case (state)
        IDLE: begin
          if (any_grant) begin
            op1_q  <= req_op1[grant_idx*WIDTH +: WIDTH];
            op2_q  <= req_op2[grant_idx*WIDTH +: WIDTH];
            id_q   <= grant_idx;
            rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            busy   <= 1'b1;
            state  <= CMP;
          end
        end
        CMP: begin
`ifdef COMPARATOR_ARBITER_PIPE_EN
          pipe_eq   <= tree_eq;
          pipe_lt   <= tree_lt;
          pipe_ltu  <= tree_ltu;
          state     <= CMP2;
        end
        CMP2: begin
          rsp_eq    <= pipe_eq;
          rsp_lt    <= pipe_lt;
          rsp_ltu   <= pipe_ltu;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RSP;
`else
          rsp_eq    <= tree_eq;
          rsp_lt    <= tree_lt;
          rsp_ltu   <= tree_ltu;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RSP;
`endif
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
